// File: rtl/led_pattern_gen_if.sv
// Configuration write port for led_pattern_gen: valid/ready handshake carrying channel, mode and half-period.
interface led_pattern_gen_if #(
  parameter int CH_W  = 2,
  parameter int DIV_W = 25
);
  logic             cfg_valid_in;
  logic             cfg_ready_out;
  logic [CH_W-1:0]  cfg_ch_in;
  logic [1:0]       cfg_mode_in;
  logic [DIV_W-1:0] cfg_half_in;

  modport master (
    output cfg_valid_in, cfg_ch_in, cfg_mode_in, cfg_half_in,
    input  cfg_ready_out
  );

  modport slave (
    input  cfg_valid_in, cfg_ch_in, cfg_mode_in, cfg_half_in,
    output cfg_ready_out
  );
endinterface

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: per-channel OFF / ON / BLINK / BREATHE with run-time configuration.
// Define LED_ACTIVE_LOW_EN to invert led_out at the output register for active-low boards.
module led_pattern_gen #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int CH_NUM   = 4,
  parameter int CH_W     = 2,
  parameter int DIV_W    = 25,
  parameter int PWM_W    = 8
) (
  input  logic                clk_in,
  input  logic                rst_in,
  led_pattern_gen_if.slave    cfg,
  output logic [CH_NUM-1:0]   led_out
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  localparam logic [DIV_W-1:0] HALF_RST = DIV_W'(CLK_FREQ / 2);
  localparam logic [PWM_W-1:0] DUTY_MAX = '1;

`ifdef LED_ACTIVE_LOW_EN
  localparam logic LED_INV = 1'b1;
`else
  localparam logic LED_INV = 1'b0;
`endif

  mode_t            r_mode [CH_NUM];
  logic [DIV_W-1:0] r_half [CH_NUM];
  logic [DIV_W-1:0] r_cnt  [CH_NUM];
  logic [PWM_W-1:0] r_duty [CH_NUM];
  logic [CH_NUM-1:0] r_phase;
  logic [CH_NUM-1:0] r_dir;
  logic [PWM_W-1:0] r_pwm_cnt;
  logic             r_ready;
  logic [CH_NUM-1:0] r_led;

  logic             w_xfer;
  logic [DIV_W-1:0] w_half_ld;
  logic [CH_NUM-1:0] w_led_nxt;

  assign w_xfer        = cfg.cfg_valid_in && r_ready;
  assign w_half_ld     = (cfg.cfg_half_in == '0) ? DIV_W'(1) : cfg.cfg_half_in;
  assign cfg.cfg_ready_out = r_ready;
  assign led_out       = r_led;

  always_comb begin
    w_led_nxt = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      case (r_mode[i])
        MODE_OFF:     w_led_nxt[i] = 1'b0;
        MODE_ON:      w_led_nxt[i] = 1'b1;
        MODE_BLINK:   w_led_nxt[i] = r_phase[i];
        MODE_BREATHE: w_led_nxt[i] = (r_pwm_cnt < r_duty[i]);
        default:      w_led_nxt[i] = 1'b0;
      endcase
    end
  end

  // dir 0 = counting up; the duty reverses at either end without overflowing
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < CH_NUM; i++) begin
        r_mode[i]  <= MODE_BLINK;
        r_half[i]  <= HALF_RST;
        r_cnt[i]   <= '0;
        r_duty[i]  <= '0;
        r_phase[i] <= ((i % 2) == 1);
        r_dir[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (w_xfer && (cfg.cfg_ch_in == CH_W'(i))) begin
          r_mode[i]  <= mode_t'(cfg.cfg_mode_in);
          r_half[i]  <= w_half_ld;
          r_cnt[i]   <= '0;
          r_duty[i]  <= '0;
          r_phase[i] <= 1'b0;
          r_dir[i]   <= 1'b0;
        end else if ((r_mode[i] == MODE_BLINK) || (r_mode[i] == MODE_BREATHE)) begin
          if (r_cnt[i] == r_half[i] - DIV_W'(1)) begin
            r_cnt[i] <= '0;
            if (r_mode[i] == MODE_BLINK) begin
              r_phase[i] <= ~r_phase[i];
            end else if (!r_dir[i]) begin
              if (r_duty[i] == DUTY_MAX) begin
                r_duty[i] <= DUTY_MAX - PWM_W'(1);
                r_dir[i]  <= 1'b1;
              end else begin
                r_duty[i] <= r_duty[i] + PWM_W'(1);
              end
            end else begin
              if (r_duty[i] == '0) begin
                r_duty[i] <= PWM_W'(1);
                r_dir[i]  <= 1'b0;
              end else begin
                r_duty[i] <= r_duty[i] - PWM_W'(1);
              end
            end
          end else begin
            r_cnt[i] <= r_cnt[i] + DIV_W'(1);
          end
        end
      end
    end
  end

  // ready drops for the single cycle after every accepted transfer, valid channel or not
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_pwm_cnt <= '0;
      r_ready   <= 1'b1;
      for (int i = 0; i < CH_NUM; i++) begin
        r_led[i] <= ((i % 2) == 1) ^ LED_INV;
      end
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
      r_ready   <= !w_xfer;
      r_led     <= w_led_nxt ^ {CH_NUM{LED_INV}};
    end
  end

endmodule
